// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, least significant digit first.
// Subtraction uses nines'-complement addition; negative results can be re-complemented to magnitude.
module bcd_serial_addsub #(
    parameter int DIGITS  = 4,
    parameter bit SIGNMAG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  op_sub,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            op_q;
    logic            cout_q;
    logic            neg_q;
    logic            err_q;

    logic [2*DIGITS-1:0] bad_digit;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
        assign bad_digit[2*gi]   = (a[4*gi +: 4] > 4'd9);
        assign bad_digit[2*gi+1] = (b[4*gi +: 4] > 4'd9);
    end

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [3:0] s_dig;
    logic [3:0] x_dig;
    logic [3:0] y_dig;
    logic [4:0] t_sum;
    logic [3:0] d_dig;
    logic       c_d;
    logic       last_dig;

    // Shared single-digit BCD adder: RUN adds (nines'-complemented) B, FIX complements the stored sum.
    always_comb begin
        a_dig = a_q[{idx_q, 2'b00} +: 4];
        b_dig = b_q[{idx_q, 2'b00} +: 4];
        s_dig = sum_q[{idx_q, 2'b00} +: 4];
        x_dig = a_dig;
        y_dig = op_q ? (4'd9 - b_dig) : b_dig;
        if (state_q == FIX) begin
            x_dig = 4'd9 - s_dig;
            y_dig = 4'd0;
        end
        t_sum = {1'b0, x_dig} + {1'b0, y_dig} + {4'b0000, carry_q};
        if (t_sum > 5'd9) begin
            d_dig = t_sum[3:0] + 4'd6;
            c_d   = 1'b1;
        end else begin
            d_dig = t_sum[3:0];
            c_d   = 1'b0;
        end
        last_dig = (idx_q == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            op_q    <= 1'b0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op_sub;
                        carry_q <= op_sub ? ~cin : cin;
                        err_q   <= |bad_digit;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= d_dig;
                    carry_q <= c_d;
                    if (last_dig) begin
                        if (!op_q) begin
                            cout_q  <= c_d;
                            neg_q   <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            // No final carry on subtract means the raw result is a ten's complement.
                            cout_q <= ~c_d;
                            if (!c_d && SIGNMAG) begin
                                idx_q   <= '0;
                                carry_q <= 1'b1;
                                state_q <= FIX;
                            end else begin
                                neg_q   <= 1'b0;
                                state_q <= DONE;
                            end
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FIX: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= d_dig;
                    carry_q <= c_d;
                    if (last_dig) begin
                        neg_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign neg       = neg_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: two instances (sign-magnitude and raw ten's complement) share stimulus
// and are checked every cycle against an integer-arithmetic model of packed-BCD add/subtract.
module tb_bcd_serial_addsub;

    localparam int D   = 4;
    localparam int W   = 4 * D;
    localparam int MOD = 10000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         op_sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         ir [2];
    logic         ov [2];
    logic         co [2];
    logic         ng [2];
    logic         er [2];
    logic [W-1:0] sm [2];

    logic [W-1:0] exp_sum [2];
    bit           exp_cout [2];
    bit           exp_neg [2];
    int           exp_lat [2];
    bit           exp_err;
    bit           chk_val;
    bit           chk_lat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(D), .SIGNMAG(1'b1)) u_sm (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .op_sub(op_sub), .cin(cin),
        .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm[0]), .cout(co[0]), .neg(ng[0]), .err(er[0])
    );

    bcd_serial_addsub #(.DIGITS(D), .SIGNMAG(1'b0)) u_tc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .op_sub(op_sub), .cin(cin),
        .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sm[1]), .cout(co[1]), .neg(ng[1]), .err(er[1])
    );

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        bit f = 1'b0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) f = 1'b1;
        return f;
    endfunction

    // Decimal arithmetic view of the result, independent of how the hardware walks the digits.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input bit msub,
                                  input bit mcin, input bit msm, output logic [W-1:0] s,
                                  output bit c, output bit n, output int lat);
        int r;
        n   = 1'b0;
        lat = D;
        if (!msub) begin
            r = bcd2int(ma) + bcd2int(mb) + int'(mcin);
            c = (r >= MOD);
            s = int2bcd(r % MOD);
        end else begin
            r = bcd2int(ma) - bcd2int(mb) - int'(mcin);
            if (r >= 0) begin
                c = 1'b0;
                s = int2bcd(r);
            end else begin
                c = 1'b1;
                if (msm) begin
                    s   = int2bcd((-r) % MOD);
                    n   = 1'b1;
                    lat = 2 * D;
                end else begin
                    s = int2bcd(r + MOD);
                end
            end
        end
    endfunction

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endfunction

    // Compare process: pins the model once, then checks both DUTs every falling edge.
    int cnt [2];
    bit busy [2];
    bit prev_ov [2];

    initial begin
        logic [W-1:0] s;
        bit c, n;
        int l;
        model(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, n, l);
        chk("pin_add_wrap", 64'({s, c, n, 8'(l)}), 64'({16'h0000, 1'b1, 1'b0, 8'd4}));
        model(16'h0500, 16'h0123, 1'b1, 1'b0, 1'b1, s, c, n, l);
        chk("pin_sub_pos", 64'({s, c, n, 8'(l)}), 64'({16'h0377, 1'b0, 1'b0, 8'd4}));
        model(16'h0500, 16'h0123, 1'b1, 1'b1, 1'b1, s, c, n, l);
        chk("pin_sub_borrow_in", 64'({s, c, n, 8'(l)}), 64'({16'h0376, 1'b0, 1'b0, 8'd4}));
        model(16'h0123, 16'h0500, 1'b1, 1'b0, 1'b1, s, c, n, l);
        chk("pin_sub_neg_sm", 64'({s, c, n, 8'(l)}), 64'({16'h0377, 1'b1, 1'b1, 8'd8}));
        model(16'h0123, 16'h0500, 1'b1, 1'b0, 1'b0, s, c, n, l);
        chk("pin_sub_neg_tc", 64'({s, c, n, 8'(l)}), 64'({16'h9623, 1'b1, 1'b0, 8'd4}));
        model(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, s, c, n, l);
        chk("pin_sub_zero", 64'({s, c, n, 8'(l)}), 64'({16'h0000, 1'b0, 1'b0, 8'd4}));
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; busy[k] = 1'b0; prev_ov[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                string tag;
                tag = (k == 0) ? "sm" : "tc";
                if (!rst_n) begin
                    chk({"reset_state_", tag}, 64'({ov[k], ir[k], sm[k], co[k], ng[k], er[k]}),
                        64'({1'b0, 1'b1, 16'h0000, 3'b000}));
                    busy[k] = 1'b0; prev_ov[k] = 1'b0; cnt[k] = 0;
                end else begin
                    cnt[k]++;
                    chk({"in_ready_", tag}, 64'(ir[k]), 64'(!busy[k]));
                    if (busy[k] && cnt[k] > 3 * D + 10) begin
                        chk({"timeout_", tag}, 64'(cnt[k]), 64'(exp_lat[k]));
                        busy[k] = 1'b0;
                    end
                    if (ov[k] === 1'b1) begin
                        if (!prev_ov[k] && chk_lat) chk({"latency_", tag}, 64'(cnt[k]), 64'(exp_lat[k]));
                        if (chk_val)
                            chk({"result_", tag}, 64'({sm[k], co[k], ng[k], er[k]}),
                                64'({exp_sum[k], exp_cout[k], exp_neg[k], exp_err}));
                        else
                            chk({"err_flag_", tag}, 64'(er[k]), 64'(exp_err));
                        if (out_ready) busy[k] = 1'b0;
                    end
                    prev_ov[k] = (ov[k] === 1'b1);
                    if (in_valid && ir[k] === 1'b1) begin
                        busy[k] = 1'b1; cnt[k] = -1; prev_ov[k] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        int p;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) begin
            p = $urandom_range(0, D - 1);
            r[4*p +: 4] = 4'($urandom_range(10, 15));
        end
        return r;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (ir[0] === 1'b1 && ir[1] === 1'b1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic set_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit tsub, input bit tcin);
        model(ta, tb_v, tsub, tcin, 1'b1, exp_sum[0], exp_cout[0], exp_neg[0], exp_lat[0]);
        model(ta, tb_v, tsub, tcin, 1'b0, exp_sum[1], exp_cout[1], exp_neg[1], exp_lat[1]);
        exp_err = has_bad(ta) | has_bad(tb_v);
        chk_val = !exp_err;
        chk_lat = !(exp_err && tsub);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit tsub,
                          input bit tcin, input int stall);
        wait_idle();
        set_exp(ta, tb_v, tsub, tcin);
        $display("op a=%h b=%h sub=%0b cin=%0b stall=%0d", ta, tb_v, tsub, tcin, stall);
        a = ta; b = tb_v; op_sub = tsub; cin = tcin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ov[0] === 1'b1 && ov[1] === 1'b1) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rand_bcd(); b = rand_bcd(); op_sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0500, 16'h0123, 1'b1, 1'b0, 0);
        run_op(16'h0500, 16'h0123, 1'b1, 1'b1, 0);
        run_op(16'h0123, 16'h0500, 1'b1, 1'b0, 0);
        run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 0);
        run_op(16'h0123, 16'h0500, 1'b1, 1'b0, 5);
        run_op(16'h0000, 16'h9999, 1'b1, 1'b1, 1);

        // Abort an operation partway through with reset, then confirm a fresh op is clean.
        set_exp(16'h4567, 16'h2899, 1'b0, 1'b0);
        $display("op a=4567 b=2899 sub=0 cin=0 aborted by reset");
        a = 16'h4567; b = 16'h2899; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h4567, 16'h2899, 1'b0, 1'b1, 0);

        for (int n = 0; n < 200; n++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
